// File: rtl/uart_rx_os.sv
// Oversampling UART receiver (16x tick).
// Frames of DBIT data bits, flags a low stop bit as a framing error.
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [4:0] S_MID  = 5'd7;
  localparam logic [4:0] S_BIT  = 5'd15;
  localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);

  logic            rx_m_q, rx_m_d;
  logic            rx_s_q, rx_s_d;
  logic [1:0]      state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  // Next-state logic: synchronizer shift and frame FSM
  always_comb begin
    rx_m_d  = rx;
    rx_s_d  = rx_m_q;
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~rx_s_q;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, async active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_m_q  <= rx_m_d;
      rx_s_q  <= rx_s_d;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule
